mem_stage: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline; consumes EX outputs, drives WB.

---
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: EX/MEM register, data-memory req/ready handshake
// with wait-state timeout, load formatting and store byte-lane steering.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic [2:0]  ex_func3,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_result,
  output logic        wb_reg_write,
  output logic        exc_misaligned,
  output logic        exc_bus_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        reg_write;
    logic        misaligned;
    logic        bus_err;
  } memwb_t;

  exmem_t  exm_q, exm_d;
  memwb_t  wb_q, wb_d;
  state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  logic        is_mem, func3_ok, addr_bad, misal, acc, timeout, stall, retire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, st_wdata;
  logic [3:0]  st_be;

  // Decode of the instruction sitting in EX/MEM
  always_comb begin
    is_mem = exm_q.valid & (exm_q.mem_read | exm_q.mem_write);
    case (exm_q.func3)
      3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
      3'b100, 3'b101:         func3_ok = ~exm_q.mem_write;
      default:                func3_ok = 1'b0;
    endcase
    case (exm_q.func3[1:0])
      2'b01:   addr_bad = exm_q.alu[0];
      2'b10:   addr_bad = |exm_q.alu[1:0];
      default: addr_bad = 1'b0;
    endcase
    misal   = is_mem & (~func3_ok | addr_bad);
    acc     = is_mem & ~misal;
    timeout = acc & (state_q == WAIT) & (timer_q == TW'(TIMEOUT_CYCLES)) & ~dmem_ready;
    stall   = acc & ~dmem_ready & ~timeout;
    retire  = exm_q.valid & ~stall;
  end

  always_comb begin
    ld_byte = dmem_rdata[{exm_q.alu[1:0], 3'b000} +: 8];
    ld_half = exm_q.alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (exm_q.func3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
    case (exm_q.func3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << exm_q.alu[1:0];
        st_wdata = {4{exm_q.data[7:0]}};
      end
      2'b01: begin
        st_be    = exm_q.alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{exm_q.data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = exm_q.data;
      end
    endcase
  end

  assign mem_stall  = stall;
  assign dmem_req   = acc;
  assign dmem_we    = acc & exm_q.mem_write;
  assign dmem_addr  = acc ? {exm_q.alu[31:2], 2'b00} : 32'b0;
  assign dmem_be    = acc ? (exm_q.mem_write ? st_be : 4'b1111) : 4'b0;
  assign dmem_wdata = (acc & exm_q.mem_write) ? st_wdata : 32'b0;

  always_comb begin
    exm_d = exm_q;
    if (!stall) begin
      exm_d.valid      = ex_valid;
      exm_d.alu        = ex_alu_result;
      exm_d.data       = ex_data;
      exm_d.rd         = ex_rd_addr;
      exm_d.func3      = ex_func3;
      exm_d.reg_write  = ex_reg_write;
      exm_d.mem_read   = ex_mem_read;
      exm_d.mem_write  = ex_mem_write;
      exm_d.mem_to_reg = ex_mem_to_reg;
    end
  end

  // MEM/WB only carries retiring instructions; anything else is an all-zero bubble
  always_comb begin
    wb_d = '0;
    if (retire) begin
      wb_d.valid      = 1'b1;
      wb_d.rd         = exm_q.rd;
      wb_d.misaligned = misal;
      wb_d.bus_err    = timeout;
      wb_d.reg_write  = exm_q.reg_write & ~misal & ~timeout;
      wb_d.result     = (exm_q.mem_read & exm_q.mem_to_reg & ~misal & ~timeout)
                        ? ld_data : exm_q.alu;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (acc && !dmem_ready) begin
          state_d = WAIT;
          timer_d = TW'(1);
        end
      end
      WAIT: begin
        if (!acc || dmem_ready || timeout) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      exm_q   <= '0;
      wb_q    <= '0;
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      exm_q   <= exm_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign wb_valid       = wb_q.valid;
  assign wb_rd_addr     = wb_q.rd;
  assign wb_result      = wb_q.result;
  assign wb_reg_write   = wb_q.reg_write;
  assign exc_misaligned = wb_q.misaligned;
  assign exc_bus_err    = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_data = '0;
  logic [4:0]  ex_rd_addr = '0;
  logic [2:0]  ex_func3 = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        wb_valid, wb_reg_write, exc_misaligned, exc_bus_err;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_(rst_),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_data(ex_data),
    .ex_rd_addr(ex_rd_addr), .ex_func3(ex_func3), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .wb_reg_write(wb_reg_write), .exc_misaligned(exc_misaligned), .exc_bus_err(exc_bus_err)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, m2r;
  } ins_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        rw, mis, berr;
  } wb_t;

  int   errors = 0;
  int   checks = 0;
  ins_t m_ins = '0;
  wb_t  m_wb = '0;
  int   m_wait = 0;
  bit   exp_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] data,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic rw, input logic mr, input logic mw);
    ins_t i;
    i = '{valid: 1'b1, alu: alu, data: data, rd: rd, f3: f3, rw: rw, mr: mr, mw: mw, m2r: mr};
    return i;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  // Legal widths: byte/half signed or unsigned, word; stores have no unsigned forms
  function automatic bit f_misal(input ins_t i);
    bit legal;
    if (!(i.mr || i.mw)) return 1'b0;
    legal = (i.f3 == 3'b010) || (i.f3[1:0] < 2'd2 && !(i.mw && i.f3[2]));
    if (!legal) return 1'b1;
    return (int'(i.alu[1:0]) % nbytes(i.f3)) != 0;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    if (n == 4) return rd;
    v = (rd >> (8 * int'(addr[1:0]))) & ((32'h1 << (8 * n)) - 32'h1);
    if (!f3[2] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [3:0] f_be(input ins_t i);
    if (!i.mw) return 4'hF;
    return 4'(((1 << nbytes(i.f3)) - 1) << int'(i.alu[1:0]));
  endfunction

  function automatic logic [31:0] f_wdata(input ins_t i);
    case (nbytes(i.f3))
      1:       return 32'h01010101 * {24'b0, i.data[7:0]};
      2:       return 32'h00010001 * {16'b0, i.data[15:0]};
      default: return i.data;
    endcase
  endfunction

  task automatic drive(input ins_t i);
    ex_valid      = i.valid;
    ex_alu_result = i.alu;
    ex_data       = i.data;
    ex_rd_addr    = i.rd;
    ex_func3      = i.f3;
    ex_reg_write  = i.rw;
    ex_mem_read   = i.mr;
    ex_mem_write  = i.mw;
    ex_mem_to_reg = i.m2r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks DUT against the model, then advances the model for the coming edge
  always @(negedge clk) begin : cmp
    bit   mis, acc, tmo, stl;
    wb_t  nx;
    ins_t cur;
    mis = m_ins.valid && f_misal(m_ins);
    acc = m_ins.valid && (m_ins.mr || m_ins.mw) && !mis;
    tmo = acc && !dmem_ready && (m_wait == TO);
    stl = acc && !dmem_ready && (m_wait < TO);

    chk("wb_valid",       32'(wb_valid),       32'(m_wb.valid));
    chk("wb_rd_addr",     32'(wb_rd_addr),     32'(m_wb.rd));
    chk("wb_result",      wb_result,           m_wb.result);
    chk("wb_reg_write",   32'(wb_reg_write),   32'(m_wb.rw));
    chk("exc_misaligned", 32'(exc_misaligned), 32'(m_wb.mis));
    chk("exc_bus_err",    32'(exc_bus_err),    32'(m_wb.berr));
    chk("mem_stall",      32'(mem_stall),      32'(stl));
    chk("dmem_req",       32'(dmem_req),       32'(acc));
    if (acc) begin
      chk("dmem_we",    32'(dmem_we),    32'(m_ins.mw));
      chk("dmem_addr",  dmem_addr,       m_ins.alu & 32'hFFFF_FFFC);
      chk("dmem_be",    32'(dmem_be),    32'(f_be(m_ins)));
      if (m_ins.mw) chk("dmem_wdata", dmem_wdata, f_wdata(m_ins));
    end

    cur = '{valid: ex_valid, alu: ex_alu_result, data: ex_data, rd: ex_rd_addr, f3: ex_func3,
            rw: ex_reg_write, mr: ex_mem_read, mw: ex_mem_write, m2r: ex_mem_to_reg};
    if (!rst_) begin
      m_ins = '0; m_wb = '0; m_wait = 0; exp_stall = 1'b1;
    end else if (!stl) begin
      nx = '0;
      if (m_ins.valid) begin
        nx.valid  = 1'b1;
        nx.rd     = m_ins.rd;
        nx.mis    = mis;
        nx.berr   = tmo;
        nx.rw     = m_ins.rw && !mis && !tmo;
        nx.result = (m_ins.mr && m_ins.m2r && !mis && !tmo)
                    ? f_load(m_ins.f3, m_ins.alu, dmem_rdata) : m_ins.alu;
      end
      m_wb = nx; m_ins = cur; m_wait = 0; exp_stall = 1'b0;
    end else begin
      m_wb = '0; m_wait++; exp_stall = 1'b1;
    end
  end

  function automatic ins_t rand_ins();
    ins_t i;
    int k;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    k = $urandom_range(2);
    i = '0;
    i.valid = ($urandom_range(9) != 0);
    i.alu   = $urandom;
    i.data  = $urandom;
    i.rd    = 5'($urandom);
    if (k == 0) begin
      i.f3 = 3'($urandom);
      i.rw = 1'b1;
    end else begin
      i.mr  = (k == 1);
      i.mw  = (k == 2);
      i.m2r = (k == 1);
      i.rw  = (k == 1);
      if ($urandom_range(9) == 0) i.f3 = 3'($urandom);
      else if (k == 1)            i.f3 = ld_f3[$urandom_range(4)];
      else                        i.f3 = 3'($urandom_range(2));
      // bias toward aligned addresses so most accesses reach the bus
      if ($urandom_range(3) != 0) i.alu[1:0] = 2'b00;
    end
    return i;
  endfunction

  ins_t nop = '0;
  int   n;
  int   pct;
  int   pcts [6] = '{100, 60, 25, 0, 85, 10};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wb_valid", 32'(wb_valid), 32'h0);
    chk("reset dmem_req", 32'(dmem_req), 32'h0);
    chk("reset mem_stall", 32'(mem_stall), 32'h0);
    tick();
    rst_ = 1'b1;

    // ADD: 1-cycle pass-through, no bus request
    drive(mk(32'd30, 32'h0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0));
    tick(); drive(nop);
    @(negedge clk); chk("add no req", 32'(dmem_req), 32'h0);
    tick();
    @(negedge clk);
    chk("add wb_valid", 32'(wb_valid), 32'h1);
    chk("add wb_result", wb_result, 32'd30);
    chk("add wb_reg_write", 32'(wb_reg_write), 32'h1);

    // LB / LBU from byte lane 3
    dmem_ready = 1'b1; dmem_rdata = 32'h80123456;
    drive(mk(32'h103, 32'h0, 5'd5, 3'b000, 1'b1, 1'b1, 1'b0));
    tick(); drive(mk(32'h103, 32'h0, 5'd6, 3'b100, 1'b1, 1'b1, 1'b0));
    @(negedge clk); chk("lb dmem_addr", dmem_addr, 32'h100);
    tick(); drive(nop);
    @(negedge clk); chk("lb wb_result", wb_result, 32'hFFFF_FF80);
    tick();
    @(negedge clk); chk("lbu wb_result", wb_result, 32'h0000_0080);

    // SH to upper half
    drive(mk(32'h102, 32'h1234ABCD, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1));
    tick(); drive(nop);
    @(negedge clk);
    chk("sh dmem_we", 32'(dmem_we), 32'h1);
    chk("sh dmem_be", 32'(dmem_be), 32'hC);
    chk("sh dmem_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh dmem_addr", dmem_addr, 32'h100);

    // LW with 3 wait states, followed back-to-back by another LW
    tick();
    drive(mk(32'h200, 32'h0, 5'd7, 3'b010, 1'b1, 1'b1, 1'b0));
    tick(); drive(mk(32'h204, 32'h0, 5'd8, 3'b010, 1'b1, 1'b1, 1'b0));
    dmem_ready = 1'b0; dmem_rdata = 32'h11111111;
    repeat (3) begin
      @(negedge clk);
      chk("lw wait stall", 32'(mem_stall), 32'h1);
      chk("lw wait addr", dmem_addr, 32'h200);
      tick();
    end
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk); chk("lw done stall", 32'(mem_stall), 32'h0);
    tick(); drive(nop); dmem_rdata = 32'h0BADBEEF;
    @(negedge clk);
    chk("lw1 wb_result", wb_result, 32'hCAFEF00D);
    chk("lw1 wb_rd", 32'(wb_rd_addr), 32'd7);
    chk("lw2 no bubble addr", dmem_addr, 32'h204);
    tick();
    @(negedge clk);
    chk("lw2 wb_result", wb_result, 32'h0BADBEEF);
    chk("lw2 wb_rd", 32'(wb_rd_addr), 32'd8);

    // Misaligned LW
    tick();
    drive(mk(32'h101, 32'h0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0));
    tick(); drive(nop);
    @(negedge clk); chk("mis no req", 32'(dmem_req), 32'h0);
    tick();
    @(negedge clk);
    chk("mis exc", 32'(exc_misaligned), 32'h1);
    chk("mis reg_write", 32'(wb_reg_write), 32'h0);

    // Timeout: ready never arrives
    tick();
    drive(mk(32'h300, 32'h0, 5'd10, 3'b010, 1'b1, 1'b1, 1'b0));
    tick(); drive(nop); dmem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall) break;
      n++;
      tick();
    end
    chk("timeout stall cycles", 32'(n), 32'd16);
    tick();
    @(negedge clk);
    chk("timeout bus_err", 32'(exc_bus_err), 32'h1);
    chk("timeout reg_write", 32'(wb_reg_write), 32'h0);
    chk("timeout stall released", 32'(mem_stall), 32'h0);

    // Reset in the middle of a wait
    tick();
    drive(mk(32'h400, 32'h0, 5'd11, 3'b010, 1'b1, 1'b1, 1'b0));
    tick(); drive(nop);
    tick(); tick();
    @(negedge clk); chk("pre-reset req", 32'(dmem_req), 32'h1);
    tick(); rst_ = 1'b0;
    tick(); rst_ = 1'b1;
    @(negedge clk);
    chk("post-reset req", 32'(dmem_req), 32'h0);
    chk("post-reset wb_valid", 32'(wb_valid), 32'h0);
    chk("post-reset stall", 32'(mem_stall), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      pct = pcts[(c / 400) % 6];
      @(posedge clk); #1;
      rst_ = ($urandom_range(699) != 0);
      if (!exp_stall) drive(rand_ins());
      dmem_ready = ($urandom_range(99) < pct);
      dmem_rdata = $urandom;
    end
    @(posedge clk); #1;
    rst_ = 1'b1; dmem_ready = 1'b1;
    if (!exp_stall) drive(nop);
    repeat (4) begin
      @(posedge clk); #1;
      if (!exp_stall) drive(nop);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
